fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 15'd0: byte address fetched first after reset; must be word-aligned.
REQ-002 clk  input  1: single clock; all state updates on rising edge.
REQ-003 rst  input  1: reset, synchronous, active-high.
REQ-004 pc  output  15: byte address driven to the instruction memory pc input; equals internal PC register.
REQ-005 insData  input  32: big-endian instruction word returned combinationally by the instruction memory for pc.
REQ-006 stall  input  1: hold PC and IF/ID contents this cycle.
REQ-007 redirect  input  1: branch/jump taken; load PC from redirect_target.
REQ-008 redirect_target  input  15: byte address of next fetch on redirect.
REQ-009 ifid_valid  output  1: IF/ID register holds a real instruction.
REQ-010 ifid_ins  output  32: latched instruction word.
REQ-011 ifid_pc  output  15: address the latched instruction was fetched from.
REQ-012 ifid_pc_plus4  output  15: ifid_pc+4 modulo 2^15.
REQ-013 misalign_err  output  1: sticky flag, a misaligned redirect target was received.

Function
REQ-014 pc output SHALL be the PC register directly, with no combinational path from any input.
REQ-015 Normal cycle (no stall, no redirect): PC <= PC+4; ifid_ins <= insData; ifid_pc <= PC; ifid_valid <= 1.
REQ-016 PC arithmetic SHALL be 15-bit modulo; PC 15'h7FFC advances to 15'h0000 with no flag.
REQ-017 Stall without redirect: PC and all ifid_* outputs SHALL hold their values.
REQ-018 Redirect SHALL take priority over stall; PC <= {redirect_target[14:2],2'b00}.
REQ-019 Redirect with redirect_target[1:0] != 0 SHALL set misalign_err, which stays 1 until reset; the fetch proceeds from the aligned address.
REQ-020 IF/ID treatment of the instruction fetched in a redirect cycle is set by REQ-026/REQ-027.
REQ-021 A flushed IF/ID slot SHALL hold ifid_valid=0 and ifid_ins=32'h00000000 (NOP); ifid_pc SHALL take PC.
REQ-022 Fetch latency: the instruction at address A SHALL appear on ifid_ins exactly one clock edge after pc=A with no stall.
REQ-023 Back-to-back redirects SHALL each take effect; the last one wins.

Reset
REQ-024 While rst=1 at a rising edge: PC <= RESET_PC; ifid_valid <= 0; ifid_ins <= 0; ifid_pc <= 0; misalign_err <= 0. rst overrides stall and redirect.
REQ-025 On the first edge after rst falls, IF/ID SHALL capture the word at RESET_PC; reset asserted mid-stream discards all in-flight state.

Configuration
REQ-026 With macro BRANCH_DELAY_SLOT_EN defined: in a redirect cycle, the word at the current PC (the delay slot) SHALL be latched into IF/ID as valid, per REQ-015, even if stall=1.
REQ-027 With BRANCH_DELAY_SLOT_EN undefined: in a redirect cycle, IF/ID SHALL be flushed per REQ-021.

Verification
REQ-028 Reset then free-run, memory words W0..W3 at 0,4,8,12 -> ifid_ins = W0,W1,W2,W3 on consecutive edges; ifid_pc = 0,4,8,12; ifid_pc_plus4 = 4,8,12,16.
REQ-029 stall=1 for 3 cycles while pc=8 -> pc stays 8; ifid_ins holds W1 throughout; W2 is captured on the first unstalled edge.
REQ-030 Redirect to 15'h0100 while pc=12 -> next pc=0x100. Macro undefined: ifid_valid=0, ifid_ins=0, then mem[0x100] is captured. Macro defined: W3 is captured valid, then mem[0x100].
REQ-031 Redirect to 15'h0102 -> pc=0x100 and misalign_err=1; it stays 1 across 10 further cycles and clears only on rst.
REQ-032 Redirect to 15'h7FF8, then free-run -> pc sequence 7FF8, 7FFC, 0000, 0004; ifid_pc_plus4 for 7FFC = 0000.
REQ-033 rst=1 asserted together with stall and redirect mid-stream -> next edge gives pc=RESET_PC, ifid_valid=0, misalign_err=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline latch with stall, redirect and flush.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched in a redirect cycle as a valid delay slot.
module fetch_stage #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] pc,
    input  logic [31:0] insData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [14:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_ins,
    output logic [14:0] ifid_pc,
    output logic [14:0] ifid_pc_plus4,
    output logic        misalign_err
);

    logic [14:0] pc_reg;
    logic        ifid_valid_reg;
    logic [31:0] ifid_ins_reg;
    logic [14:0] ifid_pc_reg;
    logic        misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC;
            ifid_valid_reg <= 1'b0;
            ifid_ins_reg   <= 32'h0000_0000;
            ifid_pc_reg    <= 15'd0;
            misalign_reg   <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over stall; the low address bits are dropped, not trapped
            pc_reg      <= {redirect_target[14:2], 2'b00};
            ifid_pc_reg <= pc_reg;
`ifdef BRANCH_DELAY_SLOT_EN
            ifid_valid_reg <= 1'b1;
            ifid_ins_reg   <= insData;
`else
            ifid_valid_reg <= 1'b0;
            ifid_ins_reg   <= 32'h0000_0000;
`endif
            if (redirect_target[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else if (!stall) begin
            pc_reg         <= pc_reg + 15'd4;
            ifid_valid_reg <= 1'b1;
            ifid_ins_reg   <= insData;
            ifid_pc_reg    <= pc_reg;
        end
    end

    assign pc            = pc_reg;
    assign ifid_valid    = ifid_valid_reg;
    assign ifid_ins      = ifid_ins_reg;
    assign ifid_pc       = ifid_pc_reg;
    assign ifid_pc_plus4 = ifid_pc_reg + 15'd4;
    assign misalign_err  = misalign_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle-level model of the fetch rules plus literal spot checks.
module tb_fetch_stage;

    localparam logic [14:0] RESET_PC = 15'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] pc;
    logic [31:0] ins_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [14:0] redirect_target = 15'd0;
    logic        ifid_valid;
    logic [31:0] ifid_ins;
    logic [14:0] ifid_pc;
    logic [14:0] ifid_pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Model state, kept as plain integers
    int  m_pc = 0;
    int  m_ipc = 0;
    bit  m_valid = 0;
    int  m_ins = 0;
    bit  m_mis = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .insData         (ins_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_ins        (ifid_ins),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .misalign_err    (misalign_err)
    );

    // Instruction memory content: every word encodes its own address
    function automatic logic [31:0] word(int a);
        return 32'hC0DE_0000 | 32'(a & 32'h7FFF);
    endfunction

    assign ins_data = word(int'(pc));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, advance the model, then compare after the edge
    task automatic cyc(bit r, bit s, bit rd, int tgt);
        rst = r;
        stall = s;
        redirect = rd;
        redirect_target = 15'(tgt);
        if (r) begin
            m_pc = int'(RESET_PC); m_valid = 0; m_ins = 0; m_ipc = 0; m_mis = 0;
        end else if (rd) begin
            m_ipc = m_pc;
`ifdef BRANCH_DELAY_SLOT_EN
            m_valid = 1; m_ins = int'(word(m_pc));
`else
            m_valid = 0; m_ins = 0;
`endif
            if (tgt % 4 != 0) m_mis = 1;
            m_pc = tgt - (tgt % 4);
        end else if (!s) begin
            m_ipc = m_pc;
            m_valid = 1;
            m_ins = int'(word(m_pc));
            m_pc = (m_pc + 4) % 32768;
        end
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("ifid_ins", ifid_ins, 32'(m_ins));
        chk("ifid_pc", 32'(ifid_pc), 32'(m_ipc));
        chk("ifid_pc_plus4", 32'(ifid_pc_plus4), 32'((m_ipc + 4) % 32768));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        $display("cycle rst=%0b stall=%0b redirect=%0b tgt=%h -> pc=%h v=%0b ins=%h ipc=%h p4=%h mis=%0b",
                 r, s, rd, 15'(tgt), pc, ifid_valid, ifid_ins, ifid_pc, ifid_pc_plus4, misalign_err);
    endtask

    initial begin
        // Reset
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("lit_reset_pc", 32'(pc), 32'h0);
        chk("lit_reset_valid", 32'(ifid_valid), 32'h0);

        // Free run from 0, then stall at pc=8
        cyc(0, 0, 0, 0);
        chk("lit_w0", ifid_ins, 32'hC0DE_0000);
        chk("lit_w0_p4", 32'(ifid_pc_plus4), 32'h4);
        cyc(0, 0, 0, 0);
        chk("lit_w1", ifid_ins, 32'hC0DE_0004);
        chk("lit_pc8", 32'(pc), 32'h8);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("lit_stall_pc", 32'(pc), 32'h8);
            chk("lit_stall_ins", ifid_ins, 32'hC0DE_0004);
        end
        cyc(0, 0, 0, 0);
        chk("lit_w2", ifid_ins, 32'hC0DE_0008);
        chk("lit_pc12", 32'(pc), 32'hC);

        // Redirect to 0x100 while pc=12
        cyc(0, 0, 1, 'h100);
        chk("lit_redir_pc", 32'(pc), 32'h100);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("lit_slot_valid", 32'(ifid_valid), 32'h1);
        chk("lit_slot_ins", ifid_ins, 32'hC0DE_000C);
`else
        chk("lit_flush_valid", 32'(ifid_valid), 32'h0);
        chk("lit_flush_ins", ifid_ins, 32'h0);
`endif
        cyc(0, 0, 0, 0);
        chk("lit_w100", ifid_ins, 32'hC0DE_0100);

        // Redirect under stall, then back-to-back redirects
        cyc(0, 1, 1, 'h200);
        chk("lit_redir_stall_pc", 32'(pc), 32'h200);
        cyc(0, 0, 1, 'h300);
        cyc(0, 0, 1, 'h400);
        chk("lit_b2b_pc", 32'(pc), 32'h400);
        cyc(0, 0, 0, 0);

        // Misaligned target: sticky flag
        cyc(0, 0, 1, 'h102);
        chk("lit_mis_pc", 32'(pc), 32'h100);
        chk("lit_mis_flag", 32'(misalign_err), 32'h1);
        for (int i = 0; i < 10; i++) cyc(0, (i % 3) == 1, 0, 0);
        chk("lit_mis_sticky", 32'(misalign_err), 32'h1);

        // Wrap at the top of the address space
        cyc(0, 0, 1, 'h7FF8);
        chk("lit_wrap_a", 32'(pc), 32'h7FF8);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_b", 32'(pc), 32'h7FFC);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_c", 32'(pc), 32'h0);
        chk("lit_wrap_p4", 32'(ifid_pc_plus4), 32'h0);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_d", 32'(pc), 32'h4);

        // Reset overrides stall and redirect mid-stream
        cyc(1, 1, 1, 'h222);
        chk("lit_rst_pc", 32'(pc), 32'h0);
        chk("lit_rst_valid", 32'(ifid_valid), 32'h0);
        chk("lit_rst_mis", 32'(misalign_err), 32'h0);
        cyc(0, 0, 0, 0);
        chk("lit_rst_w0", ifid_ins, 32'hC0DE_0000);
        cyc(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
